// File: rtl/mem_bus_arbiter.sv
// Shared memory-bus arbiter for the icache, dcache and page-table walker.
// PTW wins outright, ic/dc alternate on ties, and one transaction is outstanding at a time.
`timescale 1ns/1ps
module mem_bus_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ic_req,
  input  logic [31:0] i_ic_addr,
  input  logic        i_ic_kill,
  input  logic        i_dc_req,
  input  logic        i_dc_w_en,
  input  logic [31:0] i_dc_addr,
  input  logic [31:0] i_dc_w_data,
  input  logic        i_ptw_req,
  input  logic [31:0] i_ptw_addr,
  output logic        o_ic_ack,
  output logic        o_dc_ack,
  output logic        o_ptw_ack,
  output logic [31:0] o_r_data,
  output logic        o_mem_req,
  output logic        o_mem_w_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_w_data,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC, OWN_PTW} owner_t;

  state_t      r_state;
  owner_t      r_owner;
  logic        r_last_dc;
  logic        r_killed;
  logic        r_mem_req;
  logic        r_mem_w_en;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_w_data;

  state_t      w_state_next;
  owner_t      w_owner_next;
  logic        w_last_dc_next;
  logic        w_killed_next;
  logic        w_mem_req_next;
  logic        w_mem_w_en_next;
  logic [31:0] w_mem_addr_next;
  logic [31:0] w_mem_w_data_next;
  logic        w_ic_ok;
  logic        w_busy_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_NONE;
      r_last_dc    <= 1'b1;
      r_killed     <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_w_en   <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_w_data <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_dc    <= w_last_dc_next;
      r_killed     <= w_killed_next;
      r_mem_req    <= w_mem_req_next;
      r_mem_w_en   <= w_mem_w_en_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_w_data <= w_mem_w_data_next;
    end
  end

  // A flushing icache is not eligible for a grant in the cycle it flushes.
  assign w_ic_ok = i_ic_req & ~i_ic_kill;

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_dc_next    = r_last_dc;
    w_killed_next     = r_killed;
    w_mem_req_next    = r_mem_req;
    w_mem_w_en_next   = r_mem_w_en;
    w_mem_addr_next   = r_mem_addr;
    w_mem_w_data_next = r_mem_w_data;
    case (r_state)
      S_IDLE: begin
        if (i_ptw_req) begin
          w_state_next      = S_BUSY;
          w_owner_next      = OWN_PTW;
          w_mem_req_next    = 1'b1;
          w_mem_addr_next   = i_ptw_addr;
          w_mem_w_en_next   = 1'b0;
          w_mem_w_data_next = 32'd0;
        end else if (w_ic_ok && (!i_dc_req || r_last_dc)) begin
          w_state_next      = S_BUSY;
          w_owner_next      = OWN_IC;
          w_last_dc_next    = 1'b0;
          w_mem_req_next    = 1'b1;
          w_mem_addr_next   = i_ic_addr;
          w_mem_w_en_next   = 1'b0;
          w_mem_w_data_next = 32'd0;
        end else if (i_dc_req) begin
          w_state_next      = S_BUSY;
          w_owner_next      = OWN_DC;
          w_last_dc_next    = 1'b1;
          w_mem_req_next    = 1'b1;
          w_mem_addr_next   = i_dc_addr;
          w_mem_w_en_next   = i_dc_w_en;
          w_mem_w_data_next = i_dc_w_data;
        end
      end
      S_BUSY: begin
        if (r_owner == OWN_IC && i_ic_kill) begin
          w_killed_next = 1'b1;
        end
        // The bus transaction always completes; a kill only hides the ack.
        if (i_mem_ack) begin
          w_state_next    = S_DONE;
          w_mem_req_next  = 1'b0;
          w_mem_w_en_next = 1'b0;
          w_killed_next   = 1'b0;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_owner_next = OWN_NONE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_busy_ack = (r_state == S_BUSY) && i_mem_ack;
  assign o_ic_ack   = w_busy_ack && (r_owner == OWN_IC) && !r_killed && !i_ic_kill;
  assign o_dc_ack   = w_busy_ack && (r_owner == OWN_DC);
  assign o_ptw_ack  = w_busy_ack && (r_owner == OWN_PTW);

  assign o_r_data     = i_mem_r_data;
  assign o_mem_req    = r_mem_req;
  assign o_mem_w_en   = r_mem_w_en;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_w_data = r_mem_w_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table plus a hand-written reset-mid-BUSY sequence.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam logic [31:0] IC = 32'h0000_1000;
  localparam logic [31:0] DC = 32'h0000_2000;
  localparam logic [31:0] PT = 32'h0000_3000;
  localparam logic [31:0] WD = 32'h1234_5678;
  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req, ic_kill, dc_req, dc_w_en, ptw_req, mem_ack;
  logic        ic_ack, dc_ack, ptw_ack, mem_req, mem_w_en;
  logic [31:0] r_data, mem_addr, mem_w_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ic_req     (ic_req),
    .i_ic_addr    (IC),
    .i_ic_kill    (ic_kill),
    .i_dc_req     (dc_req),
    .i_dc_w_en    (dc_w_en),
    .i_dc_addr    (DC),
    .i_dc_w_data  (WD),
    .i_ptw_req    (ptw_req),
    .i_ptw_addr   (PT),
    .o_ic_ack     (ic_ack),
    .o_dc_ack     (dc_ack),
    .o_ptw_ack    (ptw_ack),
    .o_r_data     (r_data),
    .o_mem_req    (mem_req),
    .o_mem_w_en   (mem_w_en),
    .o_mem_addr   (mem_addr),
    .o_mem_w_data (mem_w_data),
    .i_mem_ack    (mem_ack),
    .i_mem_r_data (RD)
  );

  typedef struct {
    logic        ic, kill, dc, dcw, ptw, ack;
    logic        mreq;
    logic [31:0] maddr;
    logic        mwen;
    logic [31:0] mwdata;
    logic [2:0]  acks;   // {ptw, dc, ic}
  } vec_t;

  vec_t vecs[46];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic k, input logic d, input logic w, input logic p, input logic a);
    ic_req = i; ic_kill = k; dc_req = d; dc_w_en = w; ptw_req = p; mem_ack = a;
  endtask

  initial begin
    // ptw, ic, dc all pending from reset
    vecs[0]  = '{1,0,1,0,1,0, 0,0,0,0,3'b000};
    vecs[1]  = '{1,0,1,0,1,1, 1,PT,0,0,3'b100};
    vecs[2]  = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[3]  = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[4]  = '{1,0,1,0,0,1, 1,IC,0,0,3'b001};
    vecs[5]  = '{0,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[6]  = '{0,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[7]  = '{0,0,1,0,0,1, 1,DC,0,WD,3'b010};
    vecs[8]  = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    // ic+dc held: ic, dc, ic, dc; stray mem_ack in DONE/IDLE ignored
    vecs[9]  = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[10] = '{1,0,1,0,0,1, 1,IC,0,0,3'b001};
    vecs[11] = '{1,0,1,0,0,1, 0,0,0,0,3'b000};
    vecs[12] = '{1,0,1,0,0,1, 0,0,0,0,3'b000};
    vecs[13] = '{1,0,1,0,0,1, 1,DC,0,WD,3'b010};
    vecs[14] = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[15] = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[16] = '{1,0,1,0,0,0, 1,IC,0,0,3'b000};
    vecs[17] = '{1,0,1,0,0,1, 1,IC,0,0,3'b001};
    vecs[18] = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[19] = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[20] = '{1,0,1,0,0,1, 1,DC,0,WD,3'b010};
    vecs[21] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    // ic_kill in IDLE blocks the ic grant
    vecs[22] = '{1,1,0,0,0,0, 0,0,0,0,3'b000};
    vecs[23] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    // dc write held stable for 5 BUSY cycles
    vecs[24] = '{0,0,1,1,0,0, 0,0,0,0,3'b000};
    vecs[25] = '{0,0,1,1,0,0, 1,DC,1,WD,3'b000};
    vecs[26] = '{0,0,1,1,0,0, 1,DC,1,WD,3'b000};
    vecs[27] = '{0,0,1,1,0,0, 1,DC,1,WD,3'b000};
    vecs[28] = '{0,0,1,1,0,0, 1,DC,1,WD,3'b000};
    vecs[29] = '{0,0,1,1,0,1, 1,DC,1,WD,3'b010};
    vecs[30] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    vecs[31] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    // ic killed in BUSY: no ic_ack, then pending dc granted
    vecs[32] = '{1,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[33] = '{1,1,1,0,0,0, 1,IC,0,0,3'b000};
    vecs[34] = '{0,0,1,0,0,1, 1,IC,0,0,3'b000};
    vecs[35] = '{0,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[36] = '{0,0,1,0,0,0, 0,0,0,0,3'b000};
    vecs[37] = '{0,0,1,0,0,1, 1,DC,0,WD,3'b010};
    vecs[38] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    // single ic read, mem_ack three cycles after mem_req rises
    vecs[39] = '{1,0,0,0,0,0, 0,0,0,0,3'b000};
    vecs[40] = '{1,0,0,0,0,0, 1,IC,0,0,3'b000};
    vecs[41] = '{1,0,0,0,0,0, 1,IC,0,0,3'b000};
    vecs[42] = '{1,0,0,0,0,0, 1,IC,0,0,3'b000};
    vecs[43] = '{1,0,0,0,0,1, 1,IC,0,0,3'b001};
    vecs[44] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};
    vecs[45] = '{0,0,0,0,0,0, 0,0,0,0,3'b000};

    rst = 1'b1;
    drive(0,0,0,0,0,0);
    #3;
    chk("reset_mem_req", -1, {31'd0, mem_req}, 32'd0);
    chk("reset_mem_addr", -1, mem_addr, 32'd0);
    chk("reset_mem_w_data", -1, mem_w_data, 32'd0);
    chk("reset_acks", -1, {29'd0, ptw_ack, dc_ack, ic_ack}, 32'd0);
    #9 rst = 1'b0;

    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      drive(vecs[i].ic, vecs[i].kill, vecs[i].dc, vecs[i].dcw, vecs[i].ptw, vecs[i].ack);
      #1;
      chk("mem_req", i, {31'd0, mem_req}, {31'd0, vecs[i].mreq});
      chk("mem_w_en", i, {31'd0, mem_w_en}, {31'd0, vecs[i].mwen});
      chk("acks", i, {29'd0, ptw_ack, dc_ack, ic_ack}, {29'd0, vecs[i].acks});
      if (vecs[i].mreq) begin
        chk("mem_addr", i, mem_addr, vecs[i].maddr);
        chk("mem_w_data", i, mem_w_data, vecs[i].mwdata);
      end
      if (vecs[i].acks != 3'b000) chk("r_data", i, r_data, RD);
    end

    // reset pulse mid-BUSY abandons the transaction
    @(negedge clk); drive(1,0,0,0,0,0);
    @(negedge clk); drive(0,0,0,0,0,0);
    #1 chk("pre_rst_busy", 100, {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #0.5;
    chk("rst_mem_req", 101, {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", 101, mem_addr, 32'd0);
    #0.5 rst = 1'b0;
    mem_ack = 1'b1;
    #1 chk("rst_late_ack", 102, {29'd0, ptw_ack, dc_ack, ic_ack}, 32'd0);
    @(negedge clk); #1;
    chk("rst_idle_ack", 103, {29'd0, ptw_ack, dc_ack, ic_ack}, 32'd0);
    chk("rst_idle_req", 103, {31'd0, mem_req}, 32'd0);
    // last-grant was ic before reset; reset restores dc so ic wins the tie
    drive(1,0,1,0,0,0);
    @(negedge clk); #1;
    chk("post_rst_grant", 104, {31'd0, mem_req}, 32'd1);
    chk("post_rst_addr", 104, mem_addr, IC);
    mem_ack = 1'b1;
    #1 chk("post_rst_ack", 105, {29'd0, ptw_ack, dc_ack, ic_ack}, 32'd1);
    @(negedge clk); drive(0,0,0,0,0,0);
    #1 chk("post_rst_done", 106, {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters: none; address and data widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock for all sequential logic.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ic_req, ic_addr  input  1, 32  icache line-miss read request and address.
REQ-005 ic_kill  input  1  icache flush; abandons any icache transaction in flight.
REQ-006 dc_req, dc_w_en, dc_addr, dc_w_data  input  1, 1, 32, 32  dcache miss/writeback request (w_en=1 is a write).
REQ-007 ptw_req, ptw_addr  input  1, 32  MMU page-table-walker read request and address.
REQ-008 ic_ack, dc_ack, ptw_ack  output  1 each  per-requester completion strobe.
REQ-009 r_data  output  32  read data, a combinational pass-through of mem_r_data.
REQ-010 mem_req, mem_w_en, mem_addr, mem_w_data  output  1, 1, 32, 32  shared memory-bus request, all registered.
REQ-011 mem_ack, mem_r_data  input  1, 32  memory-bus completion and read data.

Function
REQ-012 The FSM SHALL have three states:
- IDLE: arbitrating.
- BUSY: transaction outstanding.
- DONE: one-cycle turnaround.
REQ-013 In IDLE, with any request asserted, the block SHALL grant exactly one requester per cycle.
- PTW has highest priority.
- Between ic and dc, priority is round-robin.
REQ-014 Round-robin: the block SHALL hold a last-grant flag (0 = ic, 1 = dc).
- On a simultaneous ic+dc request without ptw, the grant goes to the one not last granted.
- The flag updates only on ic or dc grants; ptw grants do not change it.
REQ-015 On a grant, the block SHALL enter BUSY in the next cycle.
- In that same edge it registers owner, mem_req=1, mem_addr, mem_w_en and mem_w_data from the winner.
- mem_w_en and mem_w_data are 0 for ic and ptw grants.
REQ-016 mem_req and all mem_* outputs SHALL stay stable throughout BUSY until mem_ack is sampled high.
REQ-017 In BUSY with mem_ack=1, the block SHALL assert the owner's ack for that same cycle (combinational from mem_ack).
- In the same cycle, r_data is valid.
- On the next edge it clears mem_req and mem_w_en and enters DONE.
REQ-018 DONE SHALL last exactly one cycle, ignore all requests and return to IDLE.
- This gives requesters one cycle to drop req after ack.
REQ-019 Minimum request-to-ack latency SHALL be 2 cycles: grant edge, then mem_ack in the first BUSY cycle.
- Back-to-back transactions are separated by one DONE cycle plus one IDLE cycle.
REQ-020 Kill: if ic_kill is asserted while ic owns BUSY, the block SHALL set a killed flag.
- The memory transaction runs to mem_ack; it is not aborted.
- ic_ack is suppressed for that transaction.
- The flag clears on entering DONE.
REQ-021 If ic_kill is asserted in IDLE while ic_req=1, the block SHALL NOT grant ic that cycle.
REQ-022 At most one of ic_ack, dc_ack or ptw_ack SHALL be high in any cycle, and only in BUSY.
REQ-023 A request that drops before it is granted SHALL be ignored; no request queueing exists.
REQ-024 mem_ack arriving in IDLE or DONE SHALL be ignored and produce no ack.

Reset
REQ-025 rst=1 SHALL asynchronously force:
- state=IDLE, mem_req=0, mem_w_en=0, mem_addr=0, mem_w_data=0;
- owner=none, last-grant=dc (so ic wins the first ic/dc tie), killed=0;
- all acks 0.
REQ-026 Reset asserted mid-BUSY SHALL abandon the transaction immediately.
- A mem_ack arriving after release is ignored per REQ-024.
REQ-027 After rst deasserts, the first grant SHALL be possible on the first clk edge.

Verification
REQ-028 Scenario: single ic_req, addr=0x0000_1000; mem_ack 3 cycles after mem_req.
- Required: mem_addr=0x1000.
- Required: ic_ack in the same cycle as mem_ack, r_data=mem_r_data=0xDEAD_BEEF.
- Required: mem_req low in the following cycle.
REQ-029 Scenario: ic_req, dc_req and ptw_req all asserted from reset, each held until acked.
- Required grant order: ptw, ic, dc.
REQ-030 Scenario: ic_req and dc_req held continuously over 4 transactions.
- Required grant order: ic, dc, ic, dc.
- Required: each transaction is separated by DONE and IDLE cycles.
REQ-031 Scenario: dc write, dc_w_en=1, addr=0x2000, data=0x1234_5678.
- Required: mem_w_en=1 and mem_w_data=0x1234_5678 held stable through 5 BUSY cycles until mem_ack.
- Required: dc_ack pulses once.
REQ-032 Scenario: ic granted, then ic_kill pulsed in BUSY, then mem_ack.
- Required: no ic_ack.
- Required: FSM passes DONE then IDLE.
- Required: a pending dc_req is granted next.
REQ-033 Scenario: rst pulsed for 1 ns mid-BUSY, then mem_ack.
- Required: mem_req=0 immediately.
- Required: no ack issued.
- Required: state=IDLE.
